// File: rtl/opsum_drain_ctrl.sv
// Opsum drain controller: scans 32 opsum FIFO lanes round-robin, pops one 16/32-bit entry per
// GLB word and writes it out. Define OPSUM_DRAIN_RELU_EN to zero negative 16-bit halves.
module opsum_drain_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pack2,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] total_words,
  input  logic [31:0]       push_opsum_en,
  input  logic [31:0]       opsum_fifo_empty,
  output logic [31:0]       pop_opsum_en,
  output logic [31:0]       pop_opsum_mod,
  input  logic [31:0][31:0] pop_opsum_data,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_waddr,
  output logic [31:0]       glb_wdata,
  input  logic              glb_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW+1:0] CntMax  = (CntW + 2)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntTwo  = CntW'(2);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  typedef enum logic [2:0] {StIdle, StScan, StPop, StCapt, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] total_q, total_d;
  logic              pack2_q, pack2_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q [32];
  logic [CntW-1:0]   cnt_d [32];

  logic              eligible;
  logic [31:0]       capt_raw, capt_val;
  logic [CntW+1:0]   sum, dec, net;

  // Shadow occupancy: the FIFO bank itself is not observable beyond its empty flags.
  always_comb begin
    sum = '0;
    dec = '0;
    net = '0;
    for (int i = 0; i < 32; i++) begin
      sum = {2'b00, cnt_q[i]} + {{(CntW + 1){1'b0}}, push_opsum_en[i]};
      dec = pop_opsum_en[i] ? {{CntW{1'b0}}, pack2_q, ~pack2_q} : '0;
      net = (sum < dec) ? '0 : sum - dec;
      cnt_d[i] = (net > CntMax) ? CntMax[CntW-1:0] : net[CntW-1:0];
    end
  end

  assign eligible = pack2_q ? (cnt_q[ptr_q] >= CntTwo)
                            : ((cnt_q[ptr_q] >= CntOne) && !opsum_fifo_empty[ptr_q]);

  always_comb begin
    capt_raw = pop_opsum_data[ptr_q];
    if (!pack2_q) capt_raw[31:16] = 16'h0;
    capt_val = capt_raw;
`ifdef OPSUM_DRAIN_RELU_EN
    if (capt_raw[31]) capt_val[31:16] = 16'h0;
    if (capt_raw[15]) capt_val[15:0]  = 16'h0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    word_cnt_d    = word_cnt_q;
    base_d        = base_q;
    total_d       = total_q;
    pack2_d       = pack2_q;
    wdata_d       = wdata_q;
    pop_opsum_en  = '0;
    pop_opsum_mod = '0;
    glb_we        = 1'b0;
    glb_waddr     = '0;
    glb_wdata     = '0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          pack2_d    = pack2;
          base_d     = base_addr;
          total_d    = total_words;
          ptr_d      = '0;
          word_cnt_d = '0;
          state_d    = (total_words == '0) ? StDone : StScan;
        end
      end
      StScan: begin
        if (eligible) state_d = StPop;
        else          ptr_d   = ptr_q + 5'd1;
      end
      StPop: begin
        pop_opsum_en[ptr_q]  = 1'b1;
        pop_opsum_mod[ptr_q] = pack2_q;
        state_d              = StCapt;
      end
      StCapt: begin
        wdata_d = capt_val;
        state_d = StWrite;
      end
      StWrite: begin
        glb_we    = 1'b1;
        glb_waddr = base_q + word_cnt_q;
        glb_wdata = wdata_q;
        if (glb_ready) begin
          word_cnt_d = word_cnt_q + AddrOne;
          ptr_d      = ptr_q + 5'd1;
          state_d    = (word_cnt_d == total_q) ? StDone : StScan;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      word_cnt_q <= '0;
      base_q     <= '0;
      total_q    <= '0;
      pack2_q    <= 1'b0;
      wdata_q    <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
      base_q     <= base_d;
      total_q    <= total_d;
      pack2_q    <= pack2_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_opsum_drain_ctrl.sv
// Bench for opsum_drain_ctrl: behavioural 32-lane FIFO bank, a write scoreboard and a pop log.
`timescale 1ns/1ps
module tb_opsum_drain_ctrl;
  localparam int unsigned AW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pack2 = 1'b0;
  logic              glb_ready = 1'b1;
  logic [AW-1:0]     base_addr = '0;
  logic [AW-1:0]     total_words = '0;
  logic [31:0]       push_opsum_en = '0;
  logic [31:0]       fifo_empty = '1;
  logic [31:0][31:0] pop_data = '0;
  logic [31:0]       pop_opsum_en, pop_opsum_mod;
  logic              glb_we, busy, done;
  logic [AW-1:0]     glb_waddr;
  logic [31:0]       glb_wdata;
  logic [15:0]       push_word = '0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_writes = 0;
  int n_done = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_w;
  int   pop_lane_log[$];
  logic pop_mod_log[$];

  logic [15:0] mem [32][16];
  int          wp [32];
  int          rp [32];
  logic [15:0] bank_lo, bank_hi;

  opsum_drain_ctrl #(.FIFO_DEPTH(8), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pack2            (pack2),
    .base_addr        (base_addr),
    .total_words      (total_words),
    .push_opsum_en    (push_opsum_en),
    .opsum_fifo_empty (fifo_empty),
    .pop_opsum_en     (pop_opsum_en),
    .pop_opsum_mod    (pop_opsum_mod),
    .pop_opsum_data   (pop_data),
    .glb_we           (glb_we),
    .glb_waddr        (glb_waddr),
    .glb_wdata        (glb_wdata),
    .glb_ready        (glb_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // FIFO bank: a 32-bit pop returns {second entry, first entry}, data one cycle after the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (pop_opsum_en[i]) begin
        bank_lo = 16'h0;
        bank_hi = 16'h0;
        if (rp[i] != wp[i]) begin bank_lo = mem[i][rp[i] % 16]; rp[i]++; end
        if (pop_opsum_mod[i] && rp[i] != wp[i]) begin bank_hi = mem[i][rp[i] % 16]; rp[i]++; end
        pop_data[i] <= {bank_hi, bank_lo};
      end
      if (push_opsum_en[i]) begin mem[i][wp[i] % 16] = push_word; wp[i]++; end
      fifo_empty[i] <= (rp[i] == wp[i]);
    end
  end

  // Scoreboard side: pop log, strobe legality and accepted GLB writes.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ($countones(pop_opsum_en) > 1 || (pop_opsum_mod & ~pop_opsum_en) != '0) begin
        n_fail++;
        $display("FAIL pop_strobe: en=%h mod=%h, required at most one en bit and mod only there",
                 pop_opsum_en, pop_opsum_mod);
      end
      for (int i = 0; i < 32; i++)
        if (pop_opsum_en[i]) begin pop_lane_log.push_back(i); pop_mod_log.push_back(pop_opsum_mod[i]); end
      if (glb_we && glb_ready) begin
        n_writes++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h, expected no write", glb_waddr, glb_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({glb_waddr, glb_wdata} !== exp_w) begin
            n_fail++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     glb_waddr, glb_wdata, exp_w[AW+31:32], exp_w[31:0]);
          end
        end
      end
      if (done) n_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_lane(input int lane, input logic [15:0] val);
    push_word           = val;
    push_opsum_en       = '0;
    push_opsum_en[lane] = 1'b1;
    tick();
    push_opsum_en = '0;
  endtask

  task automatic kick(input logic p2, input logic [AW-1:0] base, input logic [AW-1:0] total);
    pack2 = p2; base_addr = base; total_words = total; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tick();
  endtask

  // Returns at the negedge of the first WRITE cycle.
  task automatic wait_we(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (glb_we) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (pop_opsum_en !== '0) begin n_fail++; $display("FAIL rst_pop_en: got %h, expected 0", pop_opsum_en); end
    n_cmp++; if (pop_opsum_mod !== '0) begin n_fail++; $display("FAIL rst_pop_mod: got %h, expected 0", pop_opsum_mod); end
    n_cmp++; if (glb_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b, expected 0", glb_we); end
    n_cmp++; if (glb_waddr !== '0) begin n_fail++; $display("FAIL rst_waddr: got %h, expected 0", glb_waddr); end
    n_cmp++; if (glb_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h, expected 0", glb_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", done); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit seen; int d0, w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    d0 = n_done; w0 = n_writes;
    push_lane(0, 16'hAAAA);
    exp_q.push_back({16'h0100, 32'h0000AAAA});
    kick(1'b0, 16'h0100, 16'd1);
    wait_done(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL single_done: no done pulse within 200 cycles"); end
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b, expected 0", busy); end
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d, expected 1", n_done - d0); end
    n_cmp++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL single_writes: got %0d, expected 1", n_writes - w0); end
    n_cmp++;
    if (pop_lane_log.size() != 1 || pop_lane_log[0] != 0 || pop_mod_log[0] != 1'b0) begin
      n_fail++; $display("FAIL single_pop: got %0d pops, expected one on lane 0 with mod 0", pop_lane_log.size());
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_sb: %0d writes missing, expected 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_pack2();
    bit seen; int w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    w0 = n_writes;
    push_lane(1, 16'h1111);
    kick(1'b1, 16'h0200, 16'd1);
    repeat (80) tick();
    n_cmp++; if (pop_lane_log.size() != 0) begin n_fail++; $display("FAIL pack2_early_pop: got %0d pops, expected 0", pop_lane_log.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pack2_busy: got %b, expected 1", busy); end
    exp_q.push_back({16'h0200, 32'h22221111});
    push_lane(1, 16'h2222);
    wait_done(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL pack2_done: no done pulse within 200 cycles"); end
    n_cmp++;
    if (pop_lane_log.size() != 1 || pop_lane_log[0] != 1 || pop_mod_log[0] != 1'b1) begin
      n_fail++; $display("FAIL pack2_pop: got %0d pops, expected one on lane 1 with mod 1", pop_lane_log.size());
    end
    n_cmp++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL pack2_writes: got %0d, expected 1", n_writes - w0); end
  endtask

  task automatic test_two_lanes();
    bit seen; int w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    w0 = n_writes;
    push_lane(30, 16'h7030);
    push_lane(3, 16'h0333);
    exp_q.push_back({16'hFFFF, 32'h00000333});
    exp_q.push_back({16'h0000, 32'h00007030});
    kick(1'b0, 16'hFFFF, 16'd2);
    wait_done(300, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL two_done: no done pulse within 300 cycles"); end
    n_cmp++;
    if (pop_lane_log.size() != 2 || pop_lane_log[0] != 3 || pop_lane_log[1] != 30) begin
      n_fail++; $display("FAIL two_pop_order: got %0d pops, expected lane 3 then lane 30", pop_lane_log.size());
    end
    n_cmp++; if (n_writes - w0 != 2) begin n_fail++; $display("FAIL two_writes: got %0d, expected 2", n_writes - w0); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL two_sb: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit seen; int d0, w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    d0 = n_done; w0 = n_writes;
    push_lane(5, 16'h1234);
    glb_ready = 1'b0;
    exp_q.push_back({16'h0040, 32'h00001234});
    kick(1'b0, 16'h0040, 16'd1);
    wait_we(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_we: glb_we never rose within 200 cycles"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({glb_we, glb_waddr, glb_wdata} !== {1'b1, 16'h0040, 32'h00001234}) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got we=%b addr=%h data=%h, expected 1/0040/00001234",
                 k, glb_we, glb_waddr, glb_wdata);
      end
      @(negedge clk);
    end
    tick();
    start = 1'b1; base_addr = 16'h0000; total_words = 16'd5;
    tick();
    start = 1'b0;
    glb_ready = 1'b1;
    wait_done(50, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_done: no done pulse within 50 cycles"); end
    repeat (60) tick();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: busy=%b, expected 0", busy); end
    n_cmp++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL bp_writes: got %0d, expected 1", n_writes - w0); end
    n_cmp++; if (pop_lane_log.size() != 1) begin n_fail++; $display("FAIL bp_pops: got %0d, expected 1", pop_lane_log.size()); end
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d, expected 1", n_done - d0); end
    tick();
  endtask

  task automatic test_zero_words();
    int w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    w0 = n_writes;
    kick(1'b0, 16'h0500, 16'd0);
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b11) begin n_fail++; $display("FAIL zero_done: got done/busy=%b%b, expected 11", done, busy); end
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_idle: got done/busy=%b%b, expected 00", done, busy); end
    n_cmp++;
    if (pop_lane_log.size() != 0 || n_writes != w0) begin
      n_fail++; $display("FAIL zero_activity: got %0d pops %0d writes, expected 0/0", pop_lane_log.size(), n_writes - w0);
    end
    tick();
  endtask

  task automatic test_relu();
    bit seen;
    push_lane(9, 16'h0005);
    push_lane(9, 16'hFFFF);
`ifdef OPSUM_DRAIN_RELU_EN
    exp_q.push_back({16'h0600, 32'h00000005});
`else
    exp_q.push_back({16'h0600, 32'hFFFF0005});
`endif
    kick(1'b1, 16'h0600, 16'd1);
    wait_done(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL relu32_done: no done pulse within 200 cycles"); end
    push_lane(10, 16'h8001);
`ifdef OPSUM_DRAIN_RELU_EN
    exp_q.push_back({16'h0601, 32'h00000000});
`else
    exp_q.push_back({16'h0601, 32'h00008001});
`endif
    kick(1'b0, 16'h0601, 16'd1);
    wait_done(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL relu16_done: no done pulse within 200 cycles"); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL relu_sb: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen; int d0, w0;
    pop_lane_log.delete(); pop_mod_log.delete();
    d0 = n_done; w0 = n_writes;
    push_lane(7, 16'h0777);
    glb_ready = 1'b0;
    kick(1'b0, 16'h0300, 16'd1);
    wait_we(200, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rmid_we: glb_we never rose within 200 cycles"); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pop_opsum_en, pop_opsum_mod, glb_we, glb_waddr, glb_wdata, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got en=%h mod=%h we=%b addr=%h data=%h busy=%b done=%b, expected all 0",
               pop_opsum_en, pop_opsum_mod, glb_we, glb_waddr, glb_wdata, busy, done);
    end
    repeat (40) tick();
    n_cmp++; if (n_done != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses, expected 0", n_done - d0); end
    n_cmp++; if (n_writes != w0) begin n_fail++; $display("FAIL rmid_no_write: got %0d writes, expected 0", n_writes - w0); end
    n_cmp++; if (pop_lane_log.size() != 1) begin n_fail++; $display("FAIL rmid_pops: got %0d, expected 1", pop_lane_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pack2();
    test_two_lanes();
    test_backpressure();
    test_zero_words();
    test_relu();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
